// File: rtl/m_mem_access.sv
// Memory-stage access controller: one load/store per instruction over a req/ack bus.
// Optional MEM_ALIGN_CHK_EN: misaligned half/word accesses fail with m_err instead of going out.
module m_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic        m_rd,
  input  logic        m_wr,
  input  logic [1:0]  m_size,
  input  logic        m_unsigned,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] m_rdata,
  output logic        m_stall,
  output logic        m_done,
  output logic        m_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  addr_lo_q;

  logic        start;
  logic        misaligned;
  logic        timeout_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  assign start       = m_valid & (m_rd | m_wr);
  assign timeout_hit = (cnt_q == TimeoutLast);
  assign m_stall     = ((state_q == StIdle) & start) | (state_q == StBusy);

`ifdef MEM_ALIGN_CHK_EN
  always_comb begin
    misaligned = 1'b0;
    unique case (m_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = m_addr[0];
      default: misaligned = |m_addr[1:0];
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Store lane steering: enables follow the address, data is replicated across lanes.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = m_wdata;
    unique case (m_size)
      2'b00: begin
        be_next    = 4'b0001 << m_addr[1:0];
        wdata_next = {4{m_wdata[7:0]}};
      end
      2'b01: begin
        be_next    = m_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{m_wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = m_wdata;
      end
    endcase
  end

  // Load lane select and extension, driven by the type latched at start.
  always_comb begin
    lane_byte = bus_rdata[7:0];
    unique case (addr_lo_q)
      2'b00: lane_byte = bus_rdata[7:0];
      2'b01: lane_byte = bus_rdata[15:8];
      2'b10: lane_byte = bus_rdata[23:16];
      2'b11: lane_byte = bus_rdata[31:24];
      default: lane_byte = bus_rdata[7:0];
    endcase
    lane_half = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_data = bus_rdata;
    unique case (size_q)
      2'b00:   load_data = unsigned_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_data = unsigned_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'h0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_lo_q  <= 2'b00;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_be     <= 4'h0;
      bus_wdata  <= 32'h0;
      m_rdata    <= 32'h0;
      m_done     <= 1'b0;
      m_err      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          m_done <= 1'b0;
          m_err  <= 1'b0;
          if (start) begin
            if (misaligned) begin
              state_q <= StDone;
              m_done  <= 1'b1;
              m_err   <= 1'b1;
              m_rdata <= 32'h0;
            end else begin
              state_q    <= StBusy;
              cnt_q      <= 8'h0;
              size_q     <= m_size;
              unsigned_q <= m_unsigned;
              addr_lo_q  <= m_addr[1:0];
              bus_req    <= 1'b1;
              bus_we     <= m_wr;
              bus_addr   <= {m_addr[31:2], 2'b00};
              bus_be     <= be_next;
              bus_wdata  <= wdata_next;
            end
          end
        end
        StBusy: begin
          // Ack takes priority over a timeout firing in the same cycle.
          if (bus_ack) begin
            state_q <= StDone;
            bus_req <= 1'b0;
            m_rdata <= bus_we ? 32'h0 : load_data;
            m_done  <= 1'b1;
            m_err   <= 1'b0;
          end else if (timeout_hit) begin
            state_q <= StDone;
            bus_req <= 1'b0;
            m_rdata <= 32'h0;
            m_done  <= 1'b1;
            m_err   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          m_done  <= 1'b0;
          m_err   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_m_mem_access.sv
// Scoreboard bench for m_mem_access with a short timeout; honours MEM_ALIGN_CHK_EN if defined.
module tb_m_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid, m_rd, m_wr, m_unsigned;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, m_rdata;
  logic [3:0]  bus_be;
  logic        m_stall, m_done, m_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  m_mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .m_valid    (m_valid),
    .m_rd       (m_rd),
    .m_wr       (m_wr),
    .m_size     (m_size),
    .m_unsigned (m_unsigned),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .m_rdata    (m_rdata),
    .m_stall    (m_stall),
    .m_done     (m_done),
    .m_err      (m_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ack_after = 0 means never acknowledge.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_after, input logic [31:0] rdata,
                           input logic exp_we, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_stall, input int exp_req);
    int   stall_cnt = 0;
    int   req_cnt = 0;
    logic done_seen = 1'b0;
    exp_t e;
    exp_t got;
    @(posedge clk); #1;
    m_valid = 1'b1; m_rd = rd; m_wr = wr; m_size = size; m_unsigned = uns;
    m_addr = addr; m_wdata = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
      @(negedge clk);
      if (m_stall) stall_cnt++;
      if (bus_req) begin
        req_cnt++;
        check("bus_we", 32'(bus_we), 32'(exp_we));
        check("bus_addr", bus_addr, exp_addr);
        check("bus_be", 32'(bus_be), 32'(exp_be));
        check("bus_wdata", bus_wdata, exp_wdata);
        bus_rdata = rdata;
        bus_ack   = (req_cnt == ack_after);
      end
      if (m_done) begin
        done_seen = 1'b1;
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          got = sb_q.pop_front();
          check("m_rdata", m_rdata, got.rdata);
          check("m_err", 32'(m_err), 32'(got.err));
        end
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    m_valid = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
    check("done_seen", 32'(done_seen), 32'd1);
    check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    check("req_cycles", 32'(req_cnt), 32'(exp_req));
    @(negedge clk);
    check("done_pulse", 32'(m_done), 32'd0);
    check("stall_after", 32'(m_stall), 32'd0);
  endtask

  initial begin
    rst = 1'b1; m_valid = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_size = 2'b00; m_unsigned = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_be", 32'(bus_be), 32'd0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_rdata", m_rdata, 32'h0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_err", 32'(m_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // sw, ack after 1
    do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h1004, 32'hDEADBEEF, 1, 32'h0,
              1'b1, 32'h1004, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    // lb, ack after 3
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h2003, 32'h0, 3, 32'h80112233,
              1'b0, 32'h2000, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 4, 3);
    // lhu
    do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 2, 32'hBEEF1234,
              1'b0, 32'h2000, 4'b1100, 32'h0, 32'h0000BEEF, 1'b0, 3, 2);
    // timeout, no ack
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 32'h12345678,
              1'b0, 32'h40, 4'b1111, 32'h0, 32'h0, 1'b1, 5, 4);
    // lh signed right after the timeout
    do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 1, 32'h80010000,
              1'b0, 32'h40, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0, 2, 1);
    // ack on the cycle the timeout would fire
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 4, 32'h11223344,
              1'b0, 32'h10, 4'b1111, 32'h0, 32'h11223344, 1'b0, 5, 4);
    // sb lane 1
    do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h1001, 32'h123456AA, 1, 32'hFFFFFFFF,
              1'b1, 32'h1000, 4'b0010, 32'hAAAAAAAA, 32'h0, 1'b0, 2, 1);
    // sh upper half
    do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h1002, 32'h00005678, 1, 32'h0,
              1'b1, 32'h1000, 4'b1100, 32'h56785678, 32'h0, 1'b0, 2, 1);
    // rd & wr together, size 11 treated as word store
    do_access(1'b1, 1'b1, 2'b11, 1'b0, 32'h500, 32'hCAFEF00D, 2, 32'h77777777,
              1'b1, 32'h500, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 3, 2);
    // lbu lane 1
    do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h2001, 32'h0, 1, 32'h00009900,
              1'b0, 32'h2000, 4'b0010, 32'h0, 32'h00000099, 1'b0, 2, 1);
`ifdef MEM_ALIGN_CHK_EN
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h3002, 32'h0, 1, 32'hA5A5A5A5,
              1'b0, 32'h3000, 4'b1111, 32'h0, 32'h0, 1'b1, 1, 0);
`else
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h3002, 32'h0, 1, 32'hA5A5A5A5,
              1'b0, 32'h3000, 4'b1111, 32'h0, 32'hA5A5A5A5, 1'b0, 2, 1);
`endif

    // Non-memory instruction and invalid slot: no stall, no request
    @(posedge clk); #1;
    m_valid = 1'b1; m_rd = 1'b0; m_wr = 1'b0;
    @(negedge clk);
    check("nomem_stall", 32'(m_stall), 32'd0);
    @(posedge clk); #1;
    m_valid = 1'b0; m_rd = 1'b1;
    @(negedge clk);
    check("invalid_stall", 32'(m_stall), 32'd0);
    @(posedge clk); #1;
    check("idle_req", 32'(bus_req), 32'd0);
    m_rd = 1'b0;

    // Reset in BUSY, then a late ack
    m_valid = 1'b1; m_rd = 1'b1; m_size = 2'b10; m_addr = 32'h600;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; m_valid = 1'b0; m_rd = 1'b0;
    @(negedge clk);
    check("midrst_req", 32'(bus_req), 32'd0);
    check("midrst_stall", 32'(m_stall), 32'd0);
    check("midrst_done", 32'(m_done), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h55555555;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check("lateack_done", 32'(m_done), 32'd0);
    check("lateack_req", 32'(bus_req), 32'd0);
    check("lateack_rdata", m_rdata, 32'h0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
